rv_muldiv_unit: RTL and testbench
=================================

Name: rv_muldiv_unit

Overview:
- Parametrised, multi-cycle RISC-V M-extension execute unit covering MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the integer ALU in the execute stage and connects through valid/ready request and response channels.
- Multiplies go through a configurable-latency pipeline; divides use a radix-2 iterative engine.
- Results follow ISA-exact semantics for divide-by-zero and signed overflow, and carry a tag for writeback steering.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- MUL_LATENCY, 2, cycles from request acceptance to resp_valid for multiply ops (>=1).
- TAG_W, 5, width of the request/response tag (destination register index).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  abort the in-flight op, synchronous
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_a  in  XLEN  rs1 value
- req_b  in  XLEN  rs2 value
- req_tag  in  TAG_W  opaque tag
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_result  out  XLEN  result
- resp_tag  out  TAG_W  tag of the accepted request
- resp_dz  out  1  divide-by-zero occurred (DIV/DIVU/REM/REMU with b==0)

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_result=0; resp_tag=0; resp_dz=0; counters cleared.
- One op in flight at a time. req_ready=1 only in IDLE. Accept on req_valid&&req_ready at a clock edge (call it cycle 0); latch op, a, b and tag.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE->MUL (op<4) and IDLE->DIV (op>=4) on accept. DIV->DONE immediately when a special case applies.
- MUL:
  - Full 2*XLEN product, with signedness per op: MULH s*s, MULHSU s*u, MULHU u*u.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
  - Counter runs down from MUL_LATENCY-1. MUL->DONE when it reaches 0, so resp_valid rises in cycle MUL_LATENCY.
- DIV special cases, resolved with resp_valid in cycle 1:
  - b==0: DIV/DIVU give all-ones; REM/REMU give a; resp_dz=1.
  - Signed overflow (DIV/REM, a==most-negative, b==-1): DIV gives a; REM gives 0; resp_dz=0.
- DIV normal path:
  - Take magnitudes of the operands when the op is signed.
  - XLEN restoring iterations, one quotient bit per cycle.
  - Fix-up cycle: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - resp_valid rises in cycle XLEN+1.
- DONE:
  - resp_valid=1; resp_result, resp_tag and resp_dz stay stable until resp_ready.
  - On resp_valid&&resp_ready: go to IDLE; resp_valid=0 the next cycle; req_ready=1 the next cycle. There is no same-cycle re-accept.
- Throughput: one op per (latency+1) cycles when resp_ready is held high.
- flush:
  - Any state goes to IDLE next cycle; resp_valid=0; the op is discarded.
  - flush wins over a simultaneous request handshake (request not accepted) and over a simultaneous response handshake.
- rst mid-operation behaves like flush and also clears outputs to their reset values.
- Inputs req_a, req_b and req_op are don't-care after acceptance; changing them never affects the in-flight op.

Decomposition:
- Shared package rv_muldiv_pkg holds: op encodings (localparams OP_MUL..OP_REMU), FSM state typedef, and XLEN-independent helpers (is_signed_a, is_signed_b, is_div).
- One sub-module, rv_div_iter: operand magnitudes in, quotient and remainder magnitudes out, start/done strobes, XLEN-cycle restoring loop.
- Multiply pipeline and FSM stay in the top module.

Test Plan:
- MULH -> resp_valid in cycle 2 (MUL_LATENCY=2):
  - a=0x80000000, b=0x80000000 -> resp_result=0x40000000.
  - MUL with the same operands -> 0x00000000.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU with the same operands -> 0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD at cycle 33; REM with the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- Divide by zero, a=0x1234, b=0:
  - DIV -> 0xFFFFFFFF, resp_dz=1, cycle 1.
  - REMU -> 0x1234, resp_dz=1.
- Overflow, a=0x80000000, b=0xFFFFFFFF:
  - DIV -> 0x80000000, resp_dz=0, cycle 1.
  - REM -> 0.
- Backpressure: resp_ready=0 for 5 cycles after DIVU completes -> result, tag and resp_dz held stable and req_ready=0 throughout; on release, resp_valid drops and req_ready=1 the next cycle.
- flush asserted in cycle 10 of a DIV -> IDLE and req_ready=1 in cycle 11, no resp_valid for that op. Then MUL a=3, b=5, tag 9 -> result 15, resp_tag 9. Repeat with rst instead of flush -> all outputs at reset values.

Source files
------------

// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the RISC-V M-extension execute unit.
// Holds the funct3 op encodings, the FSM state type and
// XLEN-independent op-decoding helpers.
package rv_muldiv_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
    localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
    localparam logic [OP_W-1:0] OP_DIV    = 3'd4;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'd5;
    localparam logic [OP_W-1:0] OP_REM    = 3'd6;
    localparam logic [OP_W-1:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // rs1 is treated as two's complement
    function automatic logic is_signed_a(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as two's complement
    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [OP_W-1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/rv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes.
// Ports: clk, rst (sync, active-high), kill (abort), start (load operands),
//        dividend/divisor (magnitudes), done (level, set after XLEN iterations),
//        quotient/remainder (magnitudes, valid while done).
module rv_div_iter
    import rv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  divisor_q;
    logic [XLEN:0]    trial;
    logic [XLEN-1:0]  sub;
    logic             ge;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // When trial >= divisor the true difference is below divisor, so XLEN bits suffice.
    always_comb begin
        trial = {remainder, quotient[XLEN-1]};
        ge    = trial >= {1'b0, divisor_q};
        sub   = trial[XLEN-1:0] - divisor_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running   <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            divisor_q <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (kill) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            running   <= 1'b1;
            done      <= 1'b0;
            cnt       <= CNT_W'(XLEN);
            divisor_q <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (running) begin
            remainder <= ge ? sub : trial[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], ge};
            cnt       <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// RISC-V M-extension execute unit: MUL/MULH/MULHSU/MULHU via a fixed-latency
// multiply path, DIV/DIVU/REM/REMU via an iterative radix-2 divider.
// Ports: clk, rst (sync, active-high), flush (abort in-flight op),
//        req_* (valid/ready request: op, a, b, tag),
//        resp_* (valid/ready response: result, tag, dz = divide-by-zero).
module rv_muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_dz
);

    localparam int unsigned CNT_W  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam int unsigned PROD_W = 2 * XLEN;
    localparam int unsigned EXT_W  = PROD_W + 2;

    state_e             state_q, state_n;
    logic [OP_W-1:0]    op_q, op_n;
    logic [XLEN-1:0]    a_q, a_n, b_q, b_n;
    logic [TAG_W-1:0]   tag_q, tag_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               req_ready_n, resp_valid_n, resp_dz_n;
    logic [XLEN-1:0]    resp_result_n;
    logic [TAG_W-1:0]   resp_tag_n;

    // Multiply datapath on latched operands; signedness folded into a one-bit extension.
    logic signed [XLEN:0]     a_ext, b_ext;
    logic signed [EXT_W-1:0]  a_wide, b_wide;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        a_ext  = {is_signed_a(op_q) & a_q[XLEN-1], a_q};
        b_ext  = {is_signed_b(op_q) & b_q[XLEN-1], b_q};
        a_wide = EXT_W'(a_ext);
        b_wide = EXT_W'(b_ext);
        prod   = PROD_W'(a_wide * b_wide);
    end

    // Divider: magnitudes taken from the request so iterations start the cycle after accept.
    logic            div_start, div_done;
    logic [XLEN-1:0] mag_a, mag_b, div_quo, div_rem;

    always_comb begin
        mag_a = (is_signed_a(req_op) && req_a[XLEN-1]) ? -req_a : req_a;
        mag_b = (is_signed_b(req_op) && req_b[XLEN-1]) ? -req_b : req_b;
    end

    rv_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .kill      (flush),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Special cases and sign fix-up for the divide path.
    logic            b_zero, div_ovf, q_neg, r_neg;
    logic [XLEN-1:0] div_res;

    always_comb begin
        b_zero  = b_q == '0;
        div_ovf = is_signed_a(op_q) && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        q_neg   = is_signed_a(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
        r_neg   = is_signed_a(op_q) && a_q[XLEN-1];
        if (is_rem(op_q)) begin
            div_res = r_neg ? -div_rem : div_rem;
        end else begin
            div_res = q_neg ? -div_quo : div_quo;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_tag    <= '0;
            resp_dz     <= 1'b0;
        end else begin
            state_q     <= state_n;
            op_q        <= op_n;
            a_q         <= a_n;
            b_q         <= b_n;
            tag_q       <= tag_n;
            cnt_q       <= cnt_n;
            req_ready   <= req_ready_n;
            resp_valid  <= resp_valid_n;
            resp_result <= resp_result_n;
            resp_tag    <= resp_tag_n;
            resp_dz     <= resp_dz_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state_q;
        op_n          = op_q;
        a_n           = a_q;
        b_n           = b_q;
        tag_n         = tag_q;
        cnt_n         = cnt_q;
        resp_result_n = resp_result;
        resp_tag_n    = resp_tag;
        resp_dz_n     = resp_dz;
        div_start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_n      = req_op;
                    a_n       = req_a;
                    b_n       = req_b;
                    tag_n     = req_tag;
                    cnt_n     = CNT_W'(MUL_LATENCY - 1);
                    div_start = is_div(req_op);
                    state_n   = is_div(req_op) ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    state_n       = ST_DONE;
                    resp_result_n = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[PROD_W-1:XLEN];
                    resp_tag_n    = tag_q;
                    resp_dz_n     = 1'b0;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (b_zero) begin
                    state_n       = ST_DONE;
                    resp_result_n = is_rem(op_q) ? a_q : '1;
                    resp_tag_n    = tag_q;
                    resp_dz_n     = 1'b1;
                end else if (div_ovf) begin
                    state_n       = ST_DONE;
                    resp_result_n = is_rem(op_q) ? '0 : a_q;
                    resp_tag_n    = tag_q;
                    resp_dz_n     = 1'b0;
                end else if (div_done) begin
                    state_n       = ST_DONE;
                    resp_result_n = div_res;
                    resp_tag_n    = tag_q;
                    resp_dz_n     = 1'b0;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Flush beats both handshakes and leaves the visible response fields untouched.
        if (flush) begin
            state_n       = ST_IDLE;
            div_start     = 1'b0;
            resp_result_n = resp_result;
            resp_tag_n    = resp_tag;
            resp_dz_n     = resp_dz;
        end

        req_ready_n  = state_n == ST_IDLE;
        resp_valid_n = state_n == ST_DONE;
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit (XLEN=32, MUL_LATENCY=2, TAG_W=5).
module tb_rv_muldiv_unit;
    import rv_muldiv_pkg::*;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned MUL_LATENCY = 2;
    localparam int unsigned TAG_W       = 5;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_dz;

    rv_muldiv_unit #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY),
        .TAG_W       (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_tag    (resp_tag),
        .resp_dz     (resp_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rr_mode = 1;   // 0 random resp_ready, 1 held high, 2 held low

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference model: ISA arithmetic on 64-bit integers.
    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] w;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        w   = '0;
        case (op)
            OP_MUL:    w = sa * sbv;
            OP_MULH:   w = (sa * sbv) >>> 32;
            OP_MULHSU: w = (sa * longint'(ub)) >>> 32;
            OP_MULHU:  w = (ua * ub) >> 32;
            OP_DIV: begin
                if (b == 0) w = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) w = ua;
                else w = sa / sbv;
            end
            OP_DIVU:   w = (b == 0) ? '1 : ua / ub;
            OP_REM: begin
                if (b == 0) w = ua;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) w = '0;
                else w = sa % sbv;
            end
            default:   w = (b == 0) ? ua : ua % ub;
        endcase
        return w[31:0];
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 4) return MUL_LATENCY;
        if (b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Random resp_ready source.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       resp_ready = ($urandom_range(0, 3) != 0);
                2:       resp_ready = 1'b0;
                default: resp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        bit head_seen;
        bit prev_hs;
        exp_t e;
        head_seen = 0;
        prev_hs   = 0;
        forever begin
            @(negedge clk);
            if (prev_hs) begin
                chk("post_hs_resp_valid", resp_valid, 0);
                chk("post_hs_req_ready", req_ready, 1);
            end
            prev_hs = 0;
            if (resp_valid && !rst) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_resp_valid");
                end else begin
                    e = sb[0];
                    if (!head_seen) begin
                        chk("latency", cyc - e.acc, e.lat);
                        head_seen = 1;
                    end
                    chk("resp_result", resp_result, e.res);
                    chk("resp_tag", resp_tag, e.tag);
                    chk("resp_dz", resp_dz, e.dz);
                    chk("req_ready_while_valid", req_ready, 0);
                    if (resp_ready && !flush) begin
                        void'(sb.pop_front());
                        head_seen = 0;
                        prev_hs   = 1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit track,
                         input logic [31:0] eres, input logic edz);
        int   n;
        bit   ok;
        exp_t e;
        n  = 0;
        ok = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        while (!ok && n < 400) begin
            @(negedge clk);
            if (req_ready && !flush && !rst) ok = 1;
            else n++;
        end
        if (!ok) begin
            fail_now("issue_timeout");
        end else if (track) begin
            e.res = eres;
            e.tag = tag;
            e.dz  = edz;
            e.acc = cyc + 1;
            e.lat = model_lat(op, a, b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic issue_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        issue(op, a, b, tag, 1, model_res(op, a, b), (op >= 4) && (b == 0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    function automatic logic [31:0] pick_val();
        int unsigned k;
        k = $urandom_range(0, 9);
        case (k)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_resp_tag", resp_tag, 0);
        chk("rst_resp_dz", resp_dz, 0);
        rst = 1'b0;

        // Directed cases with hand-derived results.
        issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  1, 32'h4000_0000, 0);
        issue(OP_MUL,    32'h8000_0000, 32'h8000_0000, 5'd2,  1, 32'h0000_0000, 0);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  1, 32'hFFFF_FFFF, 0);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  1, 32'hFFFF_FFFE, 0);
        issue(OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd5,  1, 32'hFFFF_FFFD, 0);
        issue(OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd6,  1, 32'hFFFF_FFFF, 0);
        issue(OP_DIVU,   32'd100,       32'd7,         5'd7,  1, 32'd14,        0);
        issue(OP_REMU,   32'd100,       32'd7,         5'd8,  1, 32'd2,         0);
        issue(OP_DIV,    32'h1234,      32'd0,         5'd9,  1, 32'hFFFF_FFFF, 1);
        issue(OP_REMU,   32'h1234,      32'd0,         5'd10, 1, 32'h1234,      1);
        issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 32'h8000_0000, 0);
        issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, 32'h0000_0000, 0);
        drain();

        // Backpressure: response held for several cycles, monitor checks stability each cycle.
        begin
            int n;
            rr_mode = 2;
            issue(OP_DIVU, 32'd1000, 32'd33, 5'd13, 1, 32'd30, 0);
            n = 0;
            while (!resp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!resp_valid) fail_now("bp_wait_valid");
            repeat (5) @(negedge clk);
            rr_mode = 1;
            drain();
        end

        // Flush in cycle 10 of a divide.
        issue(OP_DIV, 32'h7FFF_1234, 32'h35, 5'd20, 0, '0, 0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_req_ready", req_ready, 1);
        chk("flush_resp_valid", resp_valid, 0);
        repeat (40) @(posedge clk);
        issue(OP_MUL, 32'd3, 32'd5, 5'd9, 1, 32'd15, 0);
        drain();

        // Reset in cycle 10 of a divide.
        issue(OP_DIV, 32'h0123_4567, 32'h89, 5'd21, 0, '0, 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_req_ready", req_ready, 1);
        chk("rst2_resp_valid", resp_valid, 0);
        chk("rst2_resp_result", resp_result, 0);
        chk("rst2_resp_tag", resp_tag, 0);
        chk("rst2_resp_dz", resp_dz, 0);
        repeat (40) @(posedge clk);
        issue(OP_MUL, 32'h10, 32'h20, 5'd3, 1, 32'h200, 0);
        drain();

        // Randomized ops against the model with random backpressure.
        rr_mode = 0;
        for (int i = 0; i < 150; i++) begin
            issue_model(3'($urandom), pick_val(), pick_val(), 5'($urandom));
        end
        rr_mode = 1;
        drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
